// File: rtl/if_stage.sv
// Instruction-fetch stage (pre-IF and IF combined) of the 5-stage myCPU pipeline.
// Keeps the PC and requests the next instruction from a synchronous SRAM with
// 1-cycle read latency. Holds the returned word while decode stalls, and hands
// {pc, inst} to decode through a valid/allowin handshake. A taken branch from
// EXE redirects the PC and cancels the wrong-path instruction in IF.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ds_allowin,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst,
   output logic        fs_adef
);

   logic        fsValid_q;
   logic        fsValid_d;
   logic [31:0] fsPc_q;
   logic [31:0] fsPc_d;
   logic [31:0] instBuf_q;
   logic [31:0] instBuf_d;
   logic        instBufValid_q;
   logic        instBufValid_d;

   logic [31:0] seqPc;
   logic [31:0] nextPc;
   logic        fsAllowin;

   // The PC resets to one word before RESET_PC so the sequential path fetches RESET_PC first.
   localparam logic [31:0] PcBeforeReset = RESET_PC - 32'd4;

   // Next-PC selection, the handshake, and the SRAM request. IF is always ready to go, and a redirect always frees IF.
   always_comb begin
      seqPc           = fsPc_q + 32'd4;
      nextPc          = br_taken ? br_target : seqPc;
      fsAllowin       = ~fsValid_q | ds_allowin | br_taken;
      inst_sram_en    = fsAllowin & ~reset;
      inst_sram_we    = 4'b0000;
      inst_sram_addr  = nextPc;
      inst_sram_wdata = 32'b0;
      fs_to_ds_valid  = fsValid_q & ~br_taken;
      fs_pc           = fsPc_q;
      fs_inst         = instBufValid_q ? instBuf_q : inst_sram_rdata;
      fs_adef         = fsValid_q & (fsPc_q[1:0] != 2'b00);
   end

   // Next-state logic. The SRAM data is only valid in the cycle right after the request, so a stalled instruction is captured then. Moving on (handshake or redirect) drops the buffer, and that takes priority over capture.
   always_comb begin
      fsValid_d      = fsValid_q;
      fsPc_d         = fsPc_q;
      instBuf_d      = instBuf_q;
      instBufValid_d = instBufValid_q;
      if (fsAllowin) begin
         fsValid_d      = 1'b1;
         fsPc_d         = nextPc;
         instBufValid_d = 1'b0;
      end else if (fsValid_q & ~ds_allowin & ~br_taken & ~instBufValid_q) begin
         instBuf_d      = inst_sram_rdata;
         instBufValid_d = 1'b1;
      end
   end

   // State registers. Reset clears them immediately, even in the middle of a cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsValid_q      <= 1'b0;
         fsPc_q         <= PcBeforeReset;
         instBuf_q      <= 32'b0;
         instBufValid_q <= 1'b0;
      end else begin
         fsValid_q      <= fsValid_d;
         fsPc_q         <= fsPc_d;
         instBuf_q      <= instBuf_d;
         instBufValid_q <= instBufValid_d;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage. A small SRAM model returns ~addr one cycle
// after each request. It can be forced to return garbage to show that a stalled
// instruction comes from the internal buffer.
module tb_if_stage;

   logic        clk;
   logic        reset;
   logic        ds_allowin;
   logic        br_taken;
   logic [31:0] br_target;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;
   logic        fs_to_ds_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        fs_adef;
   logic        garbage;

   int checks;
   int failures;

   if_stage #(.RESET_PC(32'h1c000000)) dut (
      .clk             (clk),
      .reset           (reset),
      .ds_allowin      (ds_allowin),
      .br_taken        (br_taken),
      .br_target       (br_target),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_we    (inst_sram_we),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata),
      .fs_to_ds_valid  (fs_to_ds_valid),
      .fs_pc           (fs_pc),
      .fs_inst         (fs_inst),
      .fs_adef         (fs_adef)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SRAM model with 1-cycle latency. The content of each word is the bitwise inverse of its address, and the output holds when there is no request.
   always @(posedge clk) begin
      if (garbage)
         inst_sram_rdata <= 32'hDEADBEEF;
      else if (inst_sram_en)
         inst_sram_rdata <= ~inst_sram_addr;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic allow, input logic br, input logic [31:0] tgt);
      ds_allowin = allow;
      br_taken   = br;
      br_target  = tgt;
      #1;
   endtask

   // Each cycle: inputs are applied just after the rising edge, then outputs are checked well before the next edge.
   initial begin
      checks          = 0;
      failures        = 0;
      garbage         = 1'b0;
      inst_sram_rdata = 32'h0;
      reset           = 1'b1;
      ds_allowin      = 1'b1;
      br_taken        = 1'b0;
      br_target       = 32'h0;
      #2;
      checkOutput("rst_valid", fs_to_ds_valid, 1'b0);
      checkOutput("rst_en", inst_sram_en, 1'b0);
      checkOutput("rst_adef", fs_adef, 1'b0);
      checkOutput("rst_pc", fs_pc, 32'h1bfffffc);
      checkOutput("rst_we", inst_sram_we, 4'h0);
      checkOutput("rst_wdata", inst_sram_wdata, 32'h0);
      repeat (2) @(posedge clk);
      #1;

      // Reset release and sequential fetch.
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("a_en", inst_sram_en, 1'b1);
      checkOutput("a_addr", inst_sram_addr, 32'h1c000000);
      checkOutput("a_valid", fs_to_ds_valid, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("b_valid", fs_to_ds_valid, 1'b1);
      checkOutput("b_pc", fs_pc, 32'h1c000000);
      checkOutput("b_inst", fs_inst, ~32'h1c000000);
      checkOutput("b_addr", inst_sram_addr, 32'h1c000004);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("c_pc", fs_pc, 32'h1c000004);
      checkOutput("c_inst", fs_inst, ~32'h1c000004);
      checkOutput("c_addr", inst_sram_addr, 32'h1c000008);

      // Stall for three cycles at 1c000008. The SRAM output goes to garbage while the stall lasts.
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("d_pc", fs_pc, 32'h1c000008);
      checkOutput("d_inst", fs_inst, ~32'h1c000008);
      checkOutput("d_en", inst_sram_en, 1'b0);
      checkOutput("d_valid", fs_to_ds_valid, 1'b1);
      nextCycle();
      garbage = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("e_pc", fs_pc, 32'h1c000008);
      checkOutput("e_inst", fs_inst, ~32'h1c000008);
      checkOutput("e_en", inst_sram_en, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("f_rdata_garbage", inst_sram_rdata, 32'hDEADBEEF);
      checkOutput("f_inst_held", fs_inst, ~32'h1c000008);
      checkOutput("f_pc", fs_pc, 32'h1c000008);
      checkOutput("f_valid", fs_to_ds_valid, 1'b1);
      nextCycle();
      garbage = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("g_en", inst_sram_en, 1'b1);
      checkOutput("g_addr", inst_sram_addr, 32'h1c00000c);
      checkOutput("g_inst", fs_inst, ~32'h1c000008);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("h_pc", fs_pc, 32'h1c00000c);
      checkOutput("h_inst_buf_cleared", fs_inst, ~32'h1c00000c);

      // Redirect from 1c000010 to 1c000100.
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h1c000100);
      checkOutput("i_pc", fs_pc, 32'h1c000010);
      checkOutput("i_valid_cancel", fs_to_ds_valid, 1'b0);
      checkOutput("i_addr", inst_sram_addr, 32'h1c000100);
      checkOutput("i_en", inst_sram_en, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("j_pc", fs_pc, 32'h1c000100);
      checkOutput("j_inst", fs_inst, ~32'h1c000100);
      checkOutput("j_valid", fs_to_ds_valid, 1'b1);

      // Redirect during a stall with the buffer holding the stalled instruction.
      nextCycle();
      garbage = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("k_en", inst_sram_en, 1'b0);
      checkOutput("k_inst", fs_inst, ~32'h1c000100);
      nextCycle();
      garbage = 1'b0;
      applyStimulus(1'b0, 1'b1, 32'h1c000200);
      checkOutput("l_inst_from_buf", fs_inst, ~32'h1c000100);
      checkOutput("l_en", inst_sram_en, 1'b1);
      checkOutput("l_addr", inst_sram_addr, 32'h1c000200);
      checkOutput("l_valid_cancel", fs_to_ds_valid, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("m_pc", fs_pc, 32'h1c000200);
      checkOutput("m_inst_sram", fs_inst, ~32'h1c000200);
      checkOutput("m_valid", fs_to_ds_valid, 1'b1);

      // Misaligned redirect target. The address passes through unmodified and the fetch is flagged.
      applyStimulus(1'b1, 1'b1, 32'h1c000102);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("n_pc", fs_pc, 32'h1c000102);
      checkOutput("n_adef", fs_adef, 1'b1);
      checkOutput("n_addr", inst_sram_addr, 32'h1c000106);

      // PC wrap at the top of the address space.
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'hfffffffc);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("p_pc", fs_pc, 32'hfffffffc);
      checkOutput("p_addr_wrap", inst_sram_addr, 32'h0);
      checkOutput("p_adef", fs_adef, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("q_pc", fs_pc, 32'h0);

      // Asynchronous reset asserted between clock edges.
      nextCycle();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("ar_valid", fs_to_ds_valid, 1'b0);
      checkOutput("ar_en", inst_sram_en, 1'b0);
      checkOutput("ar_pc", fs_pc, 32'h1bfffffc);
      nextCycle();
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("ar_rel_en", inst_sram_en, 1'b1);
      checkOutput("ar_rel_addr", inst_sram_addr, 32'h1c000000);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("ar_restart_pc", fs_pc, 32'h1c000000);
      checkOutput("ar_restart_valid", fs_to_ds_valid, 1'b1);
      checkOutput("ar_restart_inst", fs_inst, ~32'h1c000000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
